alu_seq: RTL and testbench

Registered, parametrised successor to the team's 8-bit combinational ALU. It adds a valid/ready handshake on both sides, generic operand width, a zero flag, and an iterative multi-cycle shift-add multiply. It sits between an operand-issue stage and a result-consume stage, and holds one operation in flight at a time.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/addsub_w.sv | 25 ++
 rtl/alu_seq.sv | 143 ++++++++++++++
 tb/tb_alu_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_GT   = 4'd5;
  localparam logic [3:0] OP_SHLA = 4'd6;
  localparam logic [3:0] OP_SHLB = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

endpackage

// File: rtl/addsub_w.sv
// Ripple-carry adder/subtractor: add_in=1 gives x+y, add_in=0 gives x+~y+1.
module addsub_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             add_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  always_comb begin
    logic             carry;
    logic [WIDTH-1:0] yy;
    sum   = '0;
    yy    = add_in ? y : ~y;
    carry = ~add_in;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i] = x[i] ^ yy[i] ^ carry;
      carry  = (x[i] & yy[i]) | (carry & (x[i] ^ yy[i]));
    end
    c_out = carry;
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and an iterative shift-add multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opCode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Carry_out,
  output logic             C_flag,
  output logic             Z_flag
);

  localparam int CW = $clog2(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   as_sum;
  logic               as_c;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               acc_co;

  assign in_ready = (state == IDLE);

  addsub_w #(.WIDTH(WIDTH)) u_addsub (
    .x      (A),
    .y      (B),
    .add_in (opCode != OP_SUB),
    .sum    (as_sum),
    .c_out  (as_c)
  );

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    case (opCode)
      OP_ADD, OP_SUB: begin
        res   = as_sum;
        res_c = as_c;
      end
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_XOR:  res = A ^ B;
      OP_GT:   res = {{(WIDTH-1){1'b0}}, (A > B)};
      OP_SHLA: begin
        res   = {A[WIDTH-2:0], 1'b0};
        res_c = A[WIDTH-1];
      end
      OP_SHLB: begin
        res   = {B[WIDTH-2:0], 1'b0};
        res_c = B[WIDTH-1];
      end
      default: begin
        res   = '0;
        res_c = 1'b0;
      end
    endcase
  end

  // Partial product for the multiplier bit selected by cnt.
  assign pp = b_q[cnt] ? ({{WIDTH{1'b0}}, a_q} << cnt) : '0;

  addsub_w #(.WIDTH(2*WIDTH)) u_acc (
    .x      (acc),
    .y      (pp),
    .add_in (1'b1),
    .sum    (acc_nxt),
    .c_out  (acc_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      Out       <= '0;
      Carry_out <= 1'b0;
      C_flag    <= 1'b0;
      Z_flag    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= A;
            b_q <= B;
            if (opCode == OP_MUL) begin
              acc   <= '0;
              cnt   <= '0;
              state <= MUL;
            end else begin
              Out       <= res;
              Carry_out <= res_c;
              C_flag    <= (A > B);
              Z_flag    <= (res == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        MUL: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
            // acc_co cannot be set by a WIDTH x WIDTH product; folded in harmlessly.
            cnt       <= '0;
            Out       <= acc_nxt[WIDTH-1:0];
            Carry_out <= (|acc_nxt[2*WIDTH-1:WIDTH]) | acc_co;
            C_flag    <= (a_q > b_q);
            Z_flag    <= (acc_nxt[WIDTH-1:0] == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq against a transaction-level model.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   opCode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Out;
  logic         Carry_out;
  logic         C_flag;
  logic         Z_flag;

  int compared   = 0;
  int mismatched = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .opCode    (opCode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out),
    .Carry_out (Carry_out),
    .C_flag    (C_flag),
    .Z_flag    (Z_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result as {Z, C, Carry, Out} from plain integer arithmetic.
  function automatic logic [W+2:0] ref_op(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint unsigned ua, ub, mask, r, cy, p;
    ua = a; ub = b; mask = (64'd1 << W) - 1; r = 0; cy = 0;
    case (op)
      4'd0: begin r = ua + ub; cy = (r > mask); r = r & mask; end
      4'd1: begin r = (ua - ub) & mask; cy = (ua >= ub); end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: r = (ua > ub);
      4'd6: begin r = (ua << 1) & mask; cy = (ua >> (W-1)) & 1; end
      4'd7: begin r = (ub << 1) & mask; cy = (ub >> (W-1)) & 1; end
      4'd8: begin p = ua * ub; r = p & mask; cy = ((p >> W) != 0); end
      default: begin r = 0; cy = 0; end
    endcase
    return {(r == 0), (ua > ub), cy[0], r[W-1:0]};
  endfunction

  // Model: phase 0 = waiting for op, 1 = multiply in progress, 2 = result offered.
  int           m_phase = 0;
  int           m_cnt   = 0;
  logic [W+2:0] m_pend  = '0;
  logic [W+2:0] m_res   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_cnt   = 0;
      m_res   = '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_pend = ref_op(opCode, A, B);
          if (opCode == 4'd8) begin
            m_phase = 1;
            m_cnt   = W;
          end else begin
            m_phase = 2;
            m_res   = m_pend;
          end
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_phase = 2;
            m_res   = m_pend;
          end
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, m_phase == 0);
      chk("out_valid", out_valid, m_phase == 2);
      if (m_phase == 2) begin
        chk("Out", Out, m_res[W-1:0]);
        chk("Carry_out", Carry_out, m_res[W]);
        chk("C_flag", C_flag, m_res[W+1]);
        chk("Z_flag", Z_flag, m_res[W+2]);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    @(posedge clk); #1;
    in_valid = 1'b1; opCode = op; A = a; B = b;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; A = ~a; B = W'($urandom); opCode = 4'($urandom);
  endtask

  task automatic wait_valid(output int n);
    bit ok;
    n = 0; ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("valid_timeout", 0, 1);
  endtask

  int n;
  int busy_hi;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; opCode = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_Out", Out, 0);
    chk("rst_flags", {Carry_out, C_flag, Z_flag}, 0);
    @(posedge clk); #3 rst_n = 1'b1;

    issue(4'd0, 8'd200, 8'd100);
    wait_valid(n);
    chk("add_latency", n, 1);
    chk("add_out", Out, 44);
    chk("add_flags", {Carry_out, C_flag, Z_flag}, 3'b110);

    issue(4'd1, 8'd5, 8'd7);
    wait_valid(n);
    chk("sub_out", Out, 254);
    chk("sub_flags", {Carry_out, C_flag, Z_flag}, 3'b000);

    issue(4'd1, 8'd7, 8'd7);
    wait_valid(n);
    chk("sub_eq_out", Out, 0);
    chk("sub_eq_flags", {Carry_out, C_flag, Z_flag}, 3'b101);

    issue(4'd8, 8'd15, 8'd17);
    wait_valid(n);
    chk("mul_latency", n, 9);
    chk("mul_out", Out, 255);
    chk("mul_carry", Carry_out, 0);
    chk("mul_done_ready", in_ready, 0);

    // Held in_valid: second op must wait until the MUL result is consumed.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; opCode = 4'd8; A = 8'd16; B = 8'd16;
    wait_valid(n);
    chk("mul2_latency", n, 10);
    chk("mul2_out", Out, 0);
    chk("mul2_flags", {Carry_out, Z_flag}, 2'b11);
    @(posedge clk); #1;
    opCode = 4'd0; A = 8'd3; B = 8'd4;
    busy_hi = 0;
    repeat (3) begin
      @(negedge clk);
      if (!in_ready && out_valid && Out == 0) busy_hi++;
    end
    chk("b2b_blocked", busy_hi, 3);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_idle_ready", in_ready, 1);
    chk("b2b_idle_valid", out_valid, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second_valid", out_valid, 1);
    chk("b2b_second_out", Out, 7);

    // Backpressure with operand scrambling after accept.
    @(posedge clk); #1 out_ready = 1'b0;
    issue(4'd4, 8'hAA, 8'h0F);
    wait_valid(n);
    chk("xor_out", Out, 8'hA5);
    busy_hi = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid && Out == 8'hA5) busy_hi++;
    end
    chk("xor_held", busy_hi, 5);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("xor_release_valid", out_valid, 1);
    @(negedge clk);
    chk("xor_single_completion", out_valid, 0);

    // Reset in the middle of a multiply.
    issue(4'd8, 8'd200, 8'd3);
    repeat (3) @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_Out", Out, 0);
    chk("mrst_flags", {Carry_out, C_flag, Z_flag}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    issue(4'd0, 8'd1, 8'd1);
    wait_valid(n);
    chk("post_rst_add", Out, 2);

    // Random traffic: model and per-cycle compare carry the checking.
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      in_valid  = $urandom_range(0, 1) != 0;
      opCode    = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      A         = W'($urandom);
      B         = W'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
